// File: rtl/mix_pkg.sv
// Shared constants, FSM encoding and index-width helper
// for the sequential mix layer.
package mix_pkg;

   localparam int HID_LENGTH_DEF = 24;
   localparam int BIT_LENGTH_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mix_state_e;

   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mix_transpose.sv
// Combinational matrix reorder: transpose when en=1,
// straight pass-through when en=0.
module mix_transpose #(
   parameter int N = 4,
   parameter int B = 8
) (
   input  logic             en,
   input  logic [N*N*B-1:0] d,
   output logic [N*N*B-1:0] q
);

   for (genvar x = 0; x < N; x++) begin : g_row
      for (genvar y = 0; y < N; y++) begin : g_col
         assign q[(x*N+y)*B +: B] = en ? d[(y*N+x)*B +: B]
                                       : d[(x*N+y)*B +: B];
      end
   end

endmodule

// File: rtl/mix_layer_seq.sv
// Sequential mix layer: issues buffered rows to an external
// row processor and collects the returned rows in order.
module mix_layer_seq
   import mix_pkg::*;
#(
   parameter int HID_LENGTH = HID_LENGTH_DEF,
   parameter int BIT_LENGTH = BIT_LENGTH_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic mode,
   input  logic [HID_LENGTH*HID_LENGTH*BIT_LENGTH-1:0] data_in,
   output logic [HID_LENGTH*BIT_LENGTH-1:0] row_out,
   output logic row_out_valid,
   input  logic row_out_ready,
   output logic [idx_w(HID_LENGTH)-1:0] row_idx,
   input  logic [HID_LENGTH*BIT_LENGTH-1:0] row_in,
   input  logic row_in_valid,
   output logic busy,
   output logic valid,
   output logic err,
   output logic [HID_LENGTH*HID_LENGTH*BIT_LENGTH-1:0] data_out
);

   localparam int N  = HID_LENGTH;
   localparam int B  = BIT_LENGTH;
   localparam int RW = N * B;
   localparam int MW = N * N * B;
   localparam int IW = idx_w(N);
   localparam int CW = idx_w(N + 1);
   localparam logic [CW-1:0] NC = CW'(N);

   mix_state_e state_q, state_d;
   logic [CW-1:0] ic_q, ic_d;
   logic [CW-1:0] cc_q, cc_d;
   logic err_q, err_d;
   logic [RW-1:0] mat_q [N];
   logic [MW-1:0] dout_q;
   logic [MW-1:0] tr;
   logic run_acc, issue, hs, cap, spur;

   mix_transpose #(.N(N), .B(B)) u_tr (
      .en (mode),
      .d  (data_in),
      .q  (tr)
   );

   assign run_acc = (state_q == IDLE) && run;
   assign issue   = (state_q == BUSY) && (ic_q < NC);
   assign hs      = issue && row_out_ready;
   // Only rows already issued may come back.
   assign cap     = row_in_valid && (state_q == BUSY)
                    && (cc_q < ic_q);
   assign spur    = row_in_valid && !cap;

   always_comb begin
      state_d = state_q;
      ic_d    = ic_q;
      cc_d    = cc_q;
      unique case (state_q)
         IDLE: begin
            if (run) begin
               state_d = BUSY;
               ic_d    = '0;
               cc_d    = '0;
            end
         end
         BUSY: begin
            if (hs) ic_d = ic_q + 1'b1;
            if (cap) begin
               cc_d = cc_q + 1'b1;
               if (cc_q == NC - 1'b1) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      err_d = (err_q && !run_acc) || spur;
   end

   always_comb begin
      row_out = '0;
      row_idx = '0;
      if (issue) begin
         row_idx = ic_q[IW-1:0];
         for (int k = 0; k < N; k++) begin
            if (ic_q == CW'(k)) row_out = mat_q[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ic_q    <= '0;
         cc_q    <= '0;
         err_q   <= 1'b0;
         dout_q  <= '0;
         for (int k = 0; k < N; k++) mat_q[k] <= '0;
      end else begin
         state_q <= state_d;
         ic_q    <= ic_d;
         cc_q    <= cc_d;
         err_q   <= err_d;
         if (run_acc) begin
            for (int k = 0; k < N; k++)
               mat_q[k] <= tr[k*RW +: RW];
         end
         if (cap) begin
            for (int k = 0; k < N; k++)
               if (cc_q == CW'(k)) dout_q[k*RW +: RW] <= row_in;
         end
      end
   end

   assign row_out_valid = issue;
   assign busy          = (state_q == BUSY);
   assign valid         = (state_q == DONE);
   assign err           = err_q;
   assign data_out      = dout_q;

endmodule

// File: tb/tb_mix_layer_seq.sv
// Directed bench for mix_layer_seq: small 4x8 instance
// plus a default-size instance for the reset scenario.
module tb_mix_layer_seq;

   localparam int N   = 4;
   localparam int B   = 8;
   localparam int RW  = N * B;
   localparam int MW  = N * N * B;
   localparam int N2  = 24;
   localparam int B2  = 16;
   localparam int RW2 = N2 * B2;
   localparam int MW2 = N2 * N2 * B2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, run, mode, rdy, riv;
   logic [MW-1:0] din, dout;
   logic [RW-1:0] row_out, rin;
   logic          rov, busy, valid, err;
   logic [1:0]    ridx;

   logic           rst2_n, run2, mode2, rdy2, riv2;
   logic [MW2-1:0] din2, dout2;
   logic [RW2-1:0] row_out2, rin2;
   logic           rov2, busy2, valid2, err2;
   logic [4:0]     ridx2;

   mix_layer_seq #(.HID_LENGTH(N), .BIT_LENGTH(B)) u_dut (
      .clk(clk), .rst_n(rst_n), .run(run), .mode(mode),
      .data_in(din), .row_out(row_out),
      .row_out_valid(rov), .row_out_ready(rdy),
      .row_idx(ridx), .row_in(rin), .row_in_valid(riv),
      .busy(busy), .valid(valid), .err(err),
      .data_out(dout)
   );

   mix_layer_seq u_big (
      .clk(clk), .rst_n(rst2_n), .run(run2), .mode(mode2),
      .data_in(din2), .row_out(row_out2),
      .row_out_valid(rov2), .row_out_ready(rdy2),
      .row_idx(ridx2), .row_in(rin2), .row_in_valid(riv2),
      .busy(busy2), .valid(valid2), .err(err2),
      .data_out(dout2)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag,
                      input logic [511:0] got,
                      input logic [511:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [MW-1:0] mk_mat();
      logic [MW-1:0] m;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            m[(r*N+c)*B +: B] = B'(16*r + c);
      return m;
   endfunction

   function automatic logic [RW-1:0] exp_row(input bit m,
                                             input int k);
      logic [RW-1:0] r;
      for (int y = 0; y < N; y++)
         r[y*B +: B] = m ? B'(16*y + k) : B'(16*k + y);
      return r;
   endfunction

   function automatic logic [MW-1:0] exp_out(input bit m);
      logic [MW-1:0] o;
      for (int k = 0; k < N; k++) o[k*RW +: RW] = exp_row(m, k);
      return o;
   endfunction

   function automatic logic [MW2-1:0] mk_big();
      logic [MW2-1:0] m;
      for (int r = 0; r < N2; r++)
         for (int c = 0; c < N2; c++)
            m[(r*N2+c)*B2 +: B2] = B2'(r*256 + c);
      return m;
   endfunction

   function automatic logic [RW2-1:0] exp_big(input bit m,
                                              input int k);
      logic [RW2-1:0] r;
      for (int y = 0; y < N2; y++)
         r[y*B2 +: B2] = m ? B2'(y*256 + k) : B2'(k*256 + y);
      return r;
   endfunction

   task automatic job(input bit m, input int lat,
                      input bit stall, output int vcyc,
                      output int nis, output int nval,
                      output bit errs);
      logic [RW-1:0] rq[$];
      int dq[$];
      logic [RW-1:0] prow;
      logic [1:0] pidx;
      bit pst, seen;
      bit pat [4];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      vcyc = -1; nis = 0; nval = 0; errs = 0;
      pst = 0; seen = 0; prow = '0; pidx = '0;
      for (int cyc = 0; cyc < 80; cyc++) begin
         @(negedge clk);
         run  = (cyc == 0);
         mode = m;
         din  = mk_mat();
         rdy  = (stall && cyc >= 1) ? pat[(cyc-1)%4] : 1'b1;
         if (dq.size() > 0 && dq[0] == cyc) begin
            riv = 1'b1;
            rin = rq.pop_front();
            void'(dq.pop_front());
         end else begin
            riv = 1'b0;
            rin = '0;
         end
         if (cyc >= 1 && err) errs = 1;
         if (valid) begin
            nval++;
            if (!seen) vcyc = cyc;
            seen = 1;
         end
         if (pst) begin
            chk("stall_row", 512'(row_out), 512'(prow));
            chk("stall_idx", 512'(ridx), 512'(pidx));
            chk("stall_vld", 512'(rov), 512'(1));
         end
         if (rov && rdy) begin
            chk("issue_row", 512'(row_out),
                512'(exp_row(m, nis)));
            chk("issue_idx", 512'(ridx), 512'(nis[1:0]));
            rq.push_back(row_out);
            dq.push_back(cyc + lat);
            nis++;
         end
         pst  = rov && !rdy;
         prow = row_out;
         pidx = ridx;
         if (seen && cyc >= vcyc + 2) break;
      end
      riv = 1'b0;
      rin = '0;
      rdy = 1'b1;
   endtask

   task automatic job_big(input bit m, input int rst_at,
                          output int vcyc);
      logic [RW2-1:0] rq[$];
      int dq[$];
      vcyc = -1;
      for (int cyc = 0; cyc < 100; cyc++) begin
         @(negedge clk);
         if (cyc == rst_at) begin
            rst2_n = 1'b0;
            run2   = 1'b0;
            riv2   = 1'b0;
            rin2   = '0;
            return;
         end
         run2  = (cyc == 0);
         mode2 = m;
         din2  = mk_big();
         if (dq.size() > 0 && dq[0] == cyc) begin
            riv2 = 1'b1;
            rin2 = rq.pop_front();
            void'(dq.pop_front());
         end else begin
            riv2 = 1'b0;
            rin2 = '0;
         end
         if (valid2) begin
            vcyc = cyc;
            break;
         end
         if (rov2) begin
            rq.push_back(row_out2);
            dq.push_back(cyc + 1);
         end
      end
      riv2 = 1'b0;
      rin2 = '0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int v, ni, nv;
      bit es;
      rst_n = 0; run = 0; mode = 0; din = '0;
      rdy = 1; riv = 0; rin = '0;
      rst2_n = 0; run2 = 0; mode2 = 0; din2 = '0;
      rdy2 = 1; riv2 = 0; rin2 = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 512'(busy), 512'(0));
      chk("rst_valid", 512'(valid), 512'(0));
      chk("rst_err", 512'(err), 512'(0));
      chk("rst_rov", 512'(rov), 512'(0));
      chk("rst_row", 512'(row_out), 512'(0));
      chk("rst_dout", 512'(dout), 512'(0));
      rst_n  = 1;
      rst2_n = 1;

      job(1'b1, 1, 1'b0, v, ni, nv, es);
      chk("t1_vcyc", 512'(v), 512'(6));
      chk("t1_nis", 512'(ni), 512'(4));
      chk("t1_nval", 512'(nv), 512'(1));
      chk("t1_err", 512'(es), 512'(0));
      chk("t1_dout", 512'(dout), 512'(exp_out(1'b1)));

      job(1'b0, 1, 1'b0, v, ni, nv, es);
      chk("t2_vcyc", 512'(v), 512'(6));
      chk("t2_nis", 512'(ni), 512'(4));
      chk("t2_dout", 512'(dout), 512'(mk_mat()));
      chk("t2_busy", 512'(busy), 512'(0));

      @(negedge clk);
      riv = 1'b1;
      rin = 32'hdeadbeef;
      @(negedge clk);
      riv = 1'b0;
      rin = '0;
      chk("t3_err", 512'(err), 512'(1));
      chk("t3_dout", 512'(dout), 512'(mk_mat()));
      job(1'b1, 1, 1'b0, v, ni, nv, es);
      chk("t3_errclr", 512'(es), 512'(0));
      chk("t3_err_end", 512'(err), 512'(0));
      chk("t3_dout2", 512'(dout), 512'(exp_out(1'b1)));

      job(1'b1, 1, 1'b1, v, ni, nv, es);
      chk("t4_nis", 512'(ni), 512'(4));
      chk("t4_nval", 512'(nv), 512'(1));
      chk("t4_err", 512'(es), 512'(0));
      chk("t4_dout", 512'(dout), 512'(exp_out(1'b1)));

      job(1'b0, 5, 1'b0, v, ni, nv, es);
      chk("t5_vcyc", 512'(v), 512'(10));
      chk("t5_nval", 512'(nv), 512'(1));
      chk("t5_err", 512'(es), 512'(0));
      chk("t5_dout", 512'(dout), 512'(mk_mat()));

      job_big(1'b1, 3, v);
      @(negedge clk);
      chk("r_busy", 512'(busy2), 512'(0));
      chk("r_valid", 512'(valid2), 512'(0));
      chk("r_rov", 512'(rov2), 512'(0));
      chk("r_err", 512'(err2), 512'(0));
      chk("r_row", 512'(row_out2), 512'(0));
      chk("r_idx", 512'(ridx2), 512'(0));
      chk("r_dout", 512'(dout2 != '0), 512'(0));
      rst2_n = 1'b1;
      riv2   = 1'b1;
      rin2   = '1;
      @(negedge clk);
      riv2 = 1'b0;
      rin2 = '0;
      chk("r_spur_err", 512'(err2), 512'(1));
      chk("r_spur_dout", 512'(dout2 != '0), 512'(0));
      job_big(1'b1, -1, v);
      chk("big_vcyc", 512'(v), 512'(N2 + 2));
      chk("big_err", 512'(err2), 512'(0));
      for (int k = 0; k < N2; k++)
         chk("big_row", 512'(dout2[k*RW2 +: RW2]),
             512'(exp_big(1'b1, k)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
